// File: rtl/tl_uncached_rr_arbiter_2.sv
// Two-client uncached TileLink arbiter: round-robin acquire with PutBlock beat locking, grants routed by id LSB.
// Zero latency, no buffering; a client's ready follows io_out_acquire_ready only while that client is chosen.
module tl_uncached_rr_arbiter_2 #(
   parameter int XACT_W = 2,
   parameter int DATA_W = 64,
   parameter int BEATS  = 8
) (
   input  logic              clk,
   input  logic              reset,

   output logic              io_in_0_acquire_ready,
   input  logic              io_in_0_acquire_valid,
   input  logic [25:0]       io_in_0_acquire_bits_addr_block,
   input  logic [XACT_W-1:0] io_in_0_acquire_bits_client_xact_id,
   input  logic [2:0]        io_in_0_acquire_bits_addr_beat,
   input  logic              io_in_0_acquire_bits_is_builtin_type,
   input  logic [2:0]        io_in_0_acquire_bits_a_type,
   input  logic [11:0]       io_in_0_acquire_bits_union,
   input  logic [DATA_W-1:0] io_in_0_acquire_bits_data,
   input  logic              io_in_0_grant_ready,
   output logic              io_in_0_grant_valid,
   output logic [2:0]        io_in_0_grant_bits_addr_beat,
   output logic [XACT_W-1:0] io_in_0_grant_bits_client_xact_id,
   output logic              io_in_0_grant_bits_manager_xact_id,
   output logic              io_in_0_grant_bits_is_builtin_type,
   output logic [3:0]        io_in_0_grant_bits_g_type,
   output logic [DATA_W-1:0] io_in_0_grant_bits_data,

   output logic              io_in_1_acquire_ready,
   input  logic              io_in_1_acquire_valid,
   input  logic [25:0]       io_in_1_acquire_bits_addr_block,
   input  logic [XACT_W-1:0] io_in_1_acquire_bits_client_xact_id,
   input  logic [2:0]        io_in_1_acquire_bits_addr_beat,
   input  logic              io_in_1_acquire_bits_is_builtin_type,
   input  logic [2:0]        io_in_1_acquire_bits_a_type,
   input  logic [11:0]       io_in_1_acquire_bits_union,
   input  logic [DATA_W-1:0] io_in_1_acquire_bits_data,
   input  logic              io_in_1_grant_ready,
   output logic              io_in_1_grant_valid,
   output logic [2:0]        io_in_1_grant_bits_addr_beat,
   output logic [XACT_W-1:0] io_in_1_grant_bits_client_xact_id,
   output logic              io_in_1_grant_bits_manager_xact_id,
   output logic              io_in_1_grant_bits_is_builtin_type,
   output logic [3:0]        io_in_1_grant_bits_g_type,
   output logic [DATA_W-1:0] io_in_1_grant_bits_data,

   input  logic              io_out_acquire_ready,
   output logic              io_out_acquire_valid,
   output logic [25:0]       io_out_acquire_bits_addr_block,
   output logic [XACT_W:0]   io_out_acquire_bits_client_xact_id,
   output logic [2:0]        io_out_acquire_bits_addr_beat,
   output logic              io_out_acquire_bits_is_builtin_type,
   output logic [2:0]        io_out_acquire_bits_a_type,
   output logic [11:0]       io_out_acquire_bits_union,
   output logic [DATA_W-1:0] io_out_acquire_bits_data,
   output logic              io_out_grant_ready,
   input  logic              io_out_grant_valid,
   input  logic [2:0]        io_out_grant_bits_addr_beat,
   input  logic [XACT_W:0]   io_out_grant_bits_client_xact_id,
   input  logic              io_out_grant_bits_manager_xact_id,
   input  logic              io_out_grant_bits_is_builtin_type,
   input  logic [3:0]        io_out_grant_bits_g_type,
   input  logic [DATA_W-1:0] io_out_grant_bits_data,

   output logic              lock_active
);

   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

   lock_state_t      state, state_nxt;
   logic             owner, owner_nxt;
   logic             last, last_nxt;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
   logic             chosen;
   logic             fire;
   logic             multi_beat;
   logic             grant_dst;

   // The favoured client is !last; if it is idle the other one gets the slot.
   always_comb begin
      chosen = owner;
      if (state == UNLOCKED) begin
         if (last ? io_in_0_acquire_valid : io_in_1_acquire_valid)
            chosen = ~last;
         else
            chosen = last;
      end
   end

   assign io_out_acquire_valid = chosen ? io_in_1_acquire_valid : io_in_0_acquire_valid;
   assign io_out_acquire_bits_addr_block = chosen ? io_in_1_acquire_bits_addr_block
                                                  : io_in_0_acquire_bits_addr_block;
   assign io_out_acquire_bits_client_xact_id =
      {(chosen ? io_in_1_acquire_bits_client_xact_id : io_in_0_acquire_bits_client_xact_id), chosen};
   assign io_out_acquire_bits_addr_beat = chosen ? io_in_1_acquire_bits_addr_beat
                                                 : io_in_0_acquire_bits_addr_beat;
   assign io_out_acquire_bits_is_builtin_type = chosen ? io_in_1_acquire_bits_is_builtin_type
                                                       : io_in_0_acquire_bits_is_builtin_type;
   assign io_out_acquire_bits_a_type = chosen ? io_in_1_acquire_bits_a_type
                                              : io_in_0_acquire_bits_a_type;
   assign io_out_acquire_bits_union = chosen ? io_in_1_acquire_bits_union
                                             : io_in_0_acquire_bits_union;
   assign io_out_acquire_bits_data = chosen ? io_in_1_acquire_bits_data
                                            : io_in_0_acquire_bits_data;

   assign fire       = io_out_acquire_valid && io_out_acquire_ready;
   assign multi_beat = io_out_acquire_bits_is_builtin_type && (io_out_acquire_bits_a_type == 3'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= UNLOCKED;
         owner    <= 1'b0;
         beat_cnt <= '0;
         last     <= 1'b1;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         beat_cnt <= beat_cnt_nxt;
         last     <= last_nxt;
      end
   end

   // Beats are counted by handshake only; addr_beat is not inspected.
   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      beat_cnt_nxt = beat_cnt;
      last_nxt     = last;
      if (fire) begin
         case (state)
            UNLOCKED: begin
               last_nxt = chosen;
               if (multi_beat) begin
                  state_nxt    = LOCKED;
                  owner_nxt    = chosen;
                  beat_cnt_nxt = CNT_W'(1);
               end
            end
            LOCKED: begin
               if (beat_cnt == LAST_BEAT) begin
                  state_nxt    = UNLOCKED;
                  beat_cnt_nxt = '0;
               end else begin
                  beat_cnt_nxt = beat_cnt + CNT_W'(1);
               end
            end
            default: state_nxt = UNLOCKED;
         endcase
      end
   end

   always_comb begin
      lock_active           = (state == LOCKED);
      io_in_0_acquire_ready = io_out_acquire_ready && !chosen;
      io_in_1_acquire_ready = io_out_acquire_ready && chosen;
   end

   // Grants route on the client index carried in the id LSB, independent of the acquire lock.
   assign grant_dst           = io_out_grant_bits_client_xact_id[0];
   assign io_in_0_grant_valid = io_out_grant_valid && !grant_dst;
   assign io_in_1_grant_valid = io_out_grant_valid && grant_dst;
   assign io_out_grant_ready  = grant_dst ? io_in_1_grant_ready : io_in_0_grant_ready;

   assign io_in_0_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
   assign io_in_0_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id[XACT_W:1];
   assign io_in_0_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
   assign io_in_0_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
   assign io_in_0_grant_bits_g_type          = io_out_grant_bits_g_type;
   assign io_in_0_grant_bits_data            = io_out_grant_bits_data;

   assign io_in_1_grant_bits_addr_beat       = io_out_grant_bits_addr_beat;
   assign io_in_1_grant_bits_client_xact_id  = io_out_grant_bits_client_xact_id[XACT_W:1];
   assign io_in_1_grant_bits_manager_xact_id = io_out_grant_bits_manager_xact_id;
   assign io_in_1_grant_bits_is_builtin_type = io_out_grant_bits_is_builtin_type;
   assign io_in_1_grant_bits_g_type          = io_out_grant_bits_g_type;
   assign io_in_1_grant_bits_data            = io_out_grant_bits_data;

endmodule

// File: tb/tb_tl_uncached_rr_arbiter_2.sv
// Directed bench for tl_uncached_rr_arbiter_2 with a cycle-level arbitration model and literal checkpoints.
module tb_tl_uncached_rr_arbiter_2;
   localparam int XACT_W = 2;
   localparam int DATA_W = 64;
   localparam int BEATS  = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              a_vld [2];
   logic [25:0]       a_blk [2];
   logic [XACT_W-1:0] a_id  [2];
   logic [2:0]        a_beat[2];
   logic              a_bi  [2];
   logic [2:0]        a_type[2];
   logic [11:0]       a_un  [2];
   logic [DATA_W-1:0] a_dat [2];
   logic              g_rdy [2];

   logic              in0_a_rdy, in1_a_rdy;
   logic              g0_vld, g1_vld;
   logic [2:0]        g0_beat, g1_beat;
   logic [XACT_W-1:0] g0_id, g1_id;
   logic              g0_mid, g1_mid, g0_bi, g1_bi;
   logic [3:0]        g0_type, g1_type;
   logic [DATA_W-1:0] g0_dat, g1_dat;

   logic              oa_rdy, oa_vld;
   logic [25:0]       oa_blk;
   logic [XACT_W:0]   oa_id;
   logic [2:0]        oa_beat;
   logic              oa_bi;
   logic [2:0]        oa_type;
   logic [11:0]       oa_un;
   logic [DATA_W-1:0] oa_dat;
   logic              og_rdy, og_vld;
   logic [2:0]        og_beat;
   logic [XACT_W:0]   og_id;
   logic              og_mid, og_bi;
   logic [3:0]        og_type;
   logic [DATA_W-1:0] og_dat;
   logic              lock_active;

   tl_uncached_rr_arbiter_2 #(.XACT_W(XACT_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk(clk), .reset(reset),
      .io_in_0_acquire_ready(in0_a_rdy), .io_in_0_acquire_valid(a_vld[0]),
      .io_in_0_acquire_bits_addr_block(a_blk[0]), .io_in_0_acquire_bits_client_xact_id(a_id[0]),
      .io_in_0_acquire_bits_addr_beat(a_beat[0]), .io_in_0_acquire_bits_is_builtin_type(a_bi[0]),
      .io_in_0_acquire_bits_a_type(a_type[0]), .io_in_0_acquire_bits_union(a_un[0]),
      .io_in_0_acquire_bits_data(a_dat[0]),
      .io_in_0_grant_ready(g_rdy[0]), .io_in_0_grant_valid(g0_vld),
      .io_in_0_grant_bits_addr_beat(g0_beat), .io_in_0_grant_bits_client_xact_id(g0_id),
      .io_in_0_grant_bits_manager_xact_id(g0_mid), .io_in_0_grant_bits_is_builtin_type(g0_bi),
      .io_in_0_grant_bits_g_type(g0_type), .io_in_0_grant_bits_data(g0_dat),
      .io_in_1_acquire_ready(in1_a_rdy), .io_in_1_acquire_valid(a_vld[1]),
      .io_in_1_acquire_bits_addr_block(a_blk[1]), .io_in_1_acquire_bits_client_xact_id(a_id[1]),
      .io_in_1_acquire_bits_addr_beat(a_beat[1]), .io_in_1_acquire_bits_is_builtin_type(a_bi[1]),
      .io_in_1_acquire_bits_a_type(a_type[1]), .io_in_1_acquire_bits_union(a_un[1]),
      .io_in_1_acquire_bits_data(a_dat[1]),
      .io_in_1_grant_ready(g_rdy[1]), .io_in_1_grant_valid(g1_vld),
      .io_in_1_grant_bits_addr_beat(g1_beat), .io_in_1_grant_bits_client_xact_id(g1_id),
      .io_in_1_grant_bits_manager_xact_id(g1_mid), .io_in_1_grant_bits_is_builtin_type(g1_bi),
      .io_in_1_grant_bits_g_type(g1_type), .io_in_1_grant_bits_data(g1_dat),
      .io_out_acquire_ready(oa_rdy), .io_out_acquire_valid(oa_vld),
      .io_out_acquire_bits_addr_block(oa_blk), .io_out_acquire_bits_client_xact_id(oa_id),
      .io_out_acquire_bits_addr_beat(oa_beat), .io_out_acquire_bits_is_builtin_type(oa_bi),
      .io_out_acquire_bits_a_type(oa_type), .io_out_acquire_bits_union(oa_un),
      .io_out_acquire_bits_data(oa_dat),
      .io_out_grant_ready(og_rdy), .io_out_grant_valid(og_vld),
      .io_out_grant_bits_addr_beat(og_beat), .io_out_grant_bits_client_xact_id(og_id),
      .io_out_grant_bits_manager_xact_id(og_mid), .io_out_grant_bits_is_builtin_type(og_bi),
      .io_out_grant_bits_g_type(og_type), .io_out_grant_bits_data(og_dat),
      .lock_active(lock_active)
   );

   int vectors = 0;
   int miscompares = 0;
   logic fires[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: beats still owed by the lock holder, the lock holder, and the last winner.
   int   m_left  = 0;
   logic m_owner = 1'b0;
   logic m_last  = 1'b1;

   always @(negedge clk) begin : model_cmp
      logic ch, ev, dst;
      if (reset) begin
         m_left  = 0;
         m_owner = 1'b0;
         m_last  = 1'b1;
      end
      if (m_left > 0)            ch = m_owner;
      else if (a_vld[!m_last])   ch = !m_last;
      else                       ch = m_last;
      ev = a_vld[ch];
      check("m_lock", 64'(lock_active), 64'(m_left > 0));
      check("m_out_vld", 64'(oa_vld), 64'(ev));
      check("m_rdy0", 64'(in0_a_rdy), 64'(oa_rdy && ch == 1'b0));
      check("m_rdy1", 64'(in1_a_rdy), 64'(oa_rdy && ch == 1'b1));
      if (ev) begin
         check("m_out_id", 64'(oa_id), 64'({a_id[ch], ch}));
         check("m_out_blk", 64'(oa_blk), 64'(a_blk[ch]));
         check("m_out_beat", 64'(oa_beat), 64'(a_beat[ch]));
         check("m_out_type", 64'({oa_bi, oa_type}), 64'({a_bi[ch], a_type[ch]}));
         check("m_out_union", 64'(oa_un), 64'(a_un[ch]));
         check("m_out_data", oa_dat, a_dat[ch]);
      end
      dst = og_id[0];
      check("m_g0_vld", 64'(g0_vld), 64'(og_vld && !dst));
      check("m_g1_vld", 64'(g1_vld), 64'(og_vld && dst));
      check("m_og_rdy", 64'(og_rdy), 64'(g_rdy[dst]));
      if (og_vld) begin
         check("m_g_id", 64'(dst ? g1_id : g0_id), 64'(og_id >> 1));
         check("m_g_data", dst ? g1_dat : g0_dat, og_dat);
         check("m_g_misc", 64'(dst ? {g1_beat, g1_mid, g1_bi, g1_type} : {g0_beat, g0_mid, g0_bi, g0_type}),
               64'({og_beat, og_mid, og_bi, og_type}));
      end
      if (!reset && oa_vld && oa_rdy) fires.push_back(in1_a_rdy);
      if (!reset && ev && oa_rdy) begin
         if (m_left > 0) m_left--;
         else begin
            m_last = ch;
            if (a_bi[ch] && a_type[ch] == 3'd3) begin
               m_left  = BEATS - 1;
               m_owner = ch;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fires(input string name, input int n_zero, input int n_total);
      check({name, "_count"}, 64'(fires.size()), 64'(n_total));
      for (int i = 0; i < fires.size(); i++)
         check({name, "_seq"}, 64'(fires[i]), 64'(i >= n_zero));
   endtask

   initial begin
      reset = 1'b1; oa_rdy = 1'b0;
      og_vld = 1'b0; og_id = '0; og_beat = '0; og_mid = 1'b0; og_bi = 1'b0; og_type = '0; og_dat = '0;
      for (int c = 0; c < 2; c++) begin
         a_vld[c] = 1'b0; a_bi[c] = 1'b1; a_type[c] = 3'd0; a_id[c] = '0; a_beat[c] = 3'(c + 1);
         a_blk[c] = 26'h0123450 + 26'(c); a_un[c] = 12'hAB0 + 12'(c); a_dat[c] = '0; g_rdy[c] = 1'b1;
      end
      step(); step();
      @(negedge clk);
      check("rst_lock", 64'(lock_active), 64'(0));
      check("rst_out_vld", 64'(oa_vld), 64'(0));
      step(); reset = 1'b0;

      // Alternating Gets from both clients.
      a_vld[0] = 1'b1; a_vld[1] = 1'b1; a_id[0] = 2'b01; a_id[1] = 2'b10;
      a_dat[0] = 64'h1111; a_dat[1] = 64'h2222; oa_rdy = 1'b1; fires.delete();
      @(negedge clk);
      check("p1_id0", 64'(oa_id), 64'(3'b010));
      check("p1_rdy0", 64'(in0_a_rdy), 64'(1));
      check("p1_rdy1", 64'(in1_a_rdy), 64'(0));
      step();
      @(negedge clk);
      check("p1_id1", 64'(oa_id), 64'(3'b101));
      step(); step(); step();
      a_vld[0] = 1'b0; a_vld[1] = 1'b0;
      check("p1_alt_count", 64'(fires.size()), 64'(4));
      for (int i = 0; i < fires.size(); i++) check("p1_alt_seq", 64'(fires[i]), 64'(i % 2));

      // Client 0 PutBlock against a pending client 1 Get.
      a_vld[0] = 1'b1; a_type[0] = 3'd3; a_id[0] = 2'b11; a_dat[0] = 64'hA000;
      a_vld[1] = 1'b1; a_id[1] = 2'b00; fires.delete();
      @(negedge clk);
      check("p2_lock_pre", 64'(lock_active), 64'(0));
      for (int b = 0; b < 8; b++) begin
         step(); a_dat[0] = 64'hA001 + 64'(b);
         @(negedge clk);
         check("p2_lock", 64'(lock_active), 64'(b < 7));
      end
      check("p2_win1", 64'(in1_a_rdy), 64'(1));
      step();
      a_vld[0] = 1'b0; a_vld[1] = 1'b0;
      check_fires("p2_fires", 8, 9);

      // PutBlock with a 3-cycle valid gap mid-burst.
      a_vld[0] = 1'b1; a_vld[1] = 1'b1; a_dat[0] = 64'hB000; fires.delete();
      step(); step(); step();
      a_vld[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("p3_gap_vld", 64'(oa_vld), 64'(0));
         check("p3_gap_rdy1", 64'(in1_a_rdy), 64'(0));
         check("p3_gap_lock", 64'(lock_active), 64'(1));
         step();
      end
      a_vld[0] = 1'b1;
      for (int b = 3; b < 8; b++) begin
         step(); a_dat[0] = 64'hB100 + 64'(b);
         @(negedge clk);
         check("p3_lock", 64'(lock_active), 64'(b < 7));
      end
      check("p3_win1", 64'(in1_a_rdy), 64'(1));
      step();
      a_vld[0] = 1'b0; a_vld[1] = 1'b0; a_type[0] = 3'd0;
      check_fires("p3_fires", 8, 9);

      // Downstream stall with both clients waiting.
      a_vld[0] = 1'b1; a_vld[1] = 1'b1; oa_rdy = 1'b0; fires.delete();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("p4_stall_rdy", 64'({in0_a_rdy, in1_a_rdy}), 64'(0));
         step();
      end
      oa_rdy = 1'b1;
      @(negedge clk);
      check("p4_win0", 64'(in0_a_rdy), 64'(1));
      step();
      a_vld[0] = 1'b0; a_vld[1] = 1'b0;
      check_fires("p4_fires", 1, 1);

      // Grant routing.
      og_vld = 1'b1; og_id = 3'b011; og_dat = 64'hDEADBEEF; og_type = 4'h5; og_beat = 3'd3; og_mid = 1'b1;
      g_rdy[1] = 1'b0; g_rdy[0] = 1'b1;
      @(negedge clk);
      check("p5_g1_vld", 64'(g1_vld), 64'(1));
      check("p5_g1_id", 64'(g1_id), 64'(2'b01));
      check("p5_g1_data", g1_dat, 64'hDEADBEEF);
      check("p5_og_rdy_hold", 64'(og_rdy), 64'(0));
      check("p5_g0_vld", 64'(g0_vld), 64'(0));
      step(); g_rdy[1] = 1'b1;
      @(negedge clk);
      check("p5_og_rdy", 64'(og_rdy), 64'(1));
      step(); og_id = 3'b100;
      @(negedge clk);
      check("p5_g0_route", 64'({g0_vld, g1_vld}), 64'(2'b10));
      check("p5_g0_id", 64'(g0_id), 64'(2'b10));
      step(); og_vld = 1'b0;

      // Reset in the middle of a PutBlock.
      a_vld[0] = 1'b1; a_type[0] = 3'd3; a_dat[0] = 64'hC000;
      step(); step(); step(); step();
      check("p6_lock_mid", 64'(lock_active), 64'(1));
      reset = 1'b1;
      #1;
      check("p6_async_unlock", 64'(lock_active), 64'(0));
      a_type[0] = 3'd0; a_vld[1] = 1'b1;
      step(); reset = 1'b0;
      @(negedge clk);
      check("p6_prio0", 64'(in0_a_rdy), 64'(1));
      check("p6_prio0_id", 64'(oa_id), 64'({a_id[0], 1'b0}));
      step();
      a_vld[0] = 1'b0; a_vld[1] = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
